serializer_arbiter: RTL and testbench

//   Round-robin scheduler that shares one serializer between NUM_REQ FFT result producers.

---
 rtl/serializer_arbiter.sv | 153 +++++++++++++++
 tb/tb_serializer_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_arbiter.sv
// -----------------------------------------------------------------------------
// serializer_arbiter
//   Round-robin scheduler that shares one serializer between NUM_REQ FFT
//   result producers. One pending frame is granted at a time. The granted
//   frame is copied into a registered data bus, and a one-cycle start pulse
//   goes to the serializer. The block then waits for the serializer's done
//   pulse. Completion, or a watchdog timeout, is reported back to the owner.
//
// Ports
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset (shared with serializer)
//   req          in   [NUM_REQ]  level request per requester
//   frame_data   in   [NUM_REQ*FRAME_WIDTH]  requester i at [i*FW +: FW]
//   grant        out  [NUM_REQ]  one-hot pulse: frame captured
//   frame_done   out  [NUM_REQ]  one-hot pulse: owner's frame serialized
//   timeout_err  out  pulse: ser_done not seen within TIMEOUT_CYCLES
//   busy         out  high while a frame is owned
//   owner        out  index of current/last granted requester
//   ser_start    out  one-cycle start pulse to serializer
//   ser_data     out  [FRAME_WIDTH] registered frame, held until next grant
//   ser_done     in   serializer completion pulse
// -----------------------------------------------------------------------------
module serializer_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int FRAME_WIDTH    = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*FRAME_WIDTH-1:0]   frame_data,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               frame_done,
  output logic                             timeout_err,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       owner,
  output logic                             ser_start,
  output logic [FRAME_WIDTH-1:0]           ser_data,
  input  logic                             ser_done
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                 state_r;
  logic [PW-1:0]          ptr_r;
  logic [TW-1:0]          timer_r;

  logic                   found_s;
  logic [PW-1:0]          sel_s;
  logic [PW:0]            idx_raw_s;
  logic [PW:0]            idx_s;
  logic [FRAME_WIDTH-1:0] sel_frame_s;
  logic [PW-1:0]          next_ptr_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first set request at or after ptr_r, wrapping modulo NUM_REQ.
  always_comb begin
    found_s   = 1'b0;
    sel_s     = {PW{1'b0}};
    idx_raw_s = {(PW+1){1'b0}};
    idx_s     = {(PW+1){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_raw_s = {1'b0, ptr_r} + (PW+1)'(i);
      idx_s     = (idx_raw_s >= (PW+1)'(NUM_REQ)) ? idx_raw_s - (PW+1)'(NUM_REQ) : idx_raw_s;
      sel_s     = (!found_s && req[idx_s[PW-1:0]]) ? idx_s[PW-1:0] : sel_s;
      found_s   = found_s | req[idx_s[PW-1:0]];
    end
  end

  // Frame mux for the selected requester.
  always_comb begin
    sel_frame_s = {FRAME_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_frame_s = (sel_s == PW'(i)) ? frame_data[i*FRAME_WIDTH +: FRAME_WIDTH] : sel_frame_s;
    end
  end

  // Pointer moves past the owner whether the transfer completed or timed out.
  always_comb begin
    next_ptr_s = (owner == PW'(NUM_REQ-1)) ? {PW{1'b0}} : owner + PW'(1);
  end

  // Scheduler FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {PW{1'b0}};
      timer_r     <= {TW{1'b0}};
      grant       <= {NUM_REQ{1'b0}};
      frame_done  <= {NUM_REQ{1'b0}};
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      owner       <= {PW{1'b0}};
      ser_start   <= 1'b0;
      ser_data    <= {FRAME_WIDTH{1'b0}};
    end else begin
      grant       <= {NUM_REQ{1'b0}};
      frame_done  <= {NUM_REQ{1'b0}};
      timeout_err <= 1'b0;
      ser_start   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // ser_done seen here is spurious and deliberately ignored.
          if (found_s) begin
            ser_data  <= sel_frame_s;
            owner     <= sel_s;
            grant     <= onehot(sel_s);
            ser_start <= 1'b1;
            timer_r   <= {TW{1'b0}};
            busy      <= 1'b1;
            state_r   <= ST_WAIT;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          timer_r <= timer_r + TW'(1);
          // Done is checked first so it wins over a coincident timeout.
          if (ser_done) begin
            frame_done <= onehot(owner);
            ptr_r      <= next_ptr_s;
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (timer_r == TW'(TIMEOUT_CYCLES-1)) begin
            timeout_err <= 1'b1;
            ptr_r       <= next_ptr_s;
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_WAIT;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_arbiter.sv
module tb_serializer_arbiter;

  localparam int FW      = 256;
  localparam int TIMEOUT = 64;

  logic          clk;
  logic          reset_n;
  logic [1:0]    req;
  logic [2*FW-1:0] frame_data;
  logic [1:0]    grant;
  logic [1:0]    frame_done;
  logic          timeout_err;
  logic          busy;
  logic [0:0]    owner;
  logic          ser_start;
  logic [FW-1:0] ser_data;
  logic          ser_done;

  int n_chk;
  int n_fail;
  int ptr_m;

  typedef struct {
    logic [1:0] req;
    int         lat;
    int         exp_k;
  } vec_t;

  vec_t vecs [9];

  serializer_arbiter #(
    .NUM_REQ(2), .FRAME_WIDTH(FW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .frame_data(frame_data),
    .grant(grant), .frame_done(frame_done), .timeout_err(timeout_err),
    .busy(busy), .owner(owner), .ser_start(ser_start), .ser_data(ser_data),
    .ser_done(ser_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand256();
    logic [FW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [1:0] oh(input int k);
    logic [1:0] one;
    one = 2'b01;
    return one << k;
  endfunction

  // Reference round robin: first requester at or after ptr, modulo 2.
  function automatic int rr_pick(input int p, input logic [1:0] r);
    int k;
    for (int j = 0; j < 2; j++) begin
      k = (p + j) % 2;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, " grant"}, grant, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " timeout_err"}, timeout_err, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " owner"}, owner, 0);
    chk({tag, " ser_start"}, ser_start, 0);
    chk({tag, " ser_data"}, ser_data, 0);
  endtask

  // One transfer: serializer answers lat cycles after the start cycle
  // (lat >= TIMEOUT means it never answers in time).
  task automatic run_xfer(input logic [1:0] r, input int lat, input int exp_k,
                          input logic [1:0] wait_req);
    logic [FW-1:0] f0, f1, exp_f;
    bit done_exp;
    int last;
    f0 = rand256();
    f1 = rand256();
    exp_f = (exp_k == 1) ? f1 : f0;
    frame_data = {f1, f0};
    req = r;
    ser_done = 1'b0;
    tick();
    chk("grant", grant, oh(exp_k));
    chk("ser_start", ser_start, 1);
    chk("busy_start", busy, 1);
    chk("owner", owner, exp_k);
    chk("ser_data", ser_data, exp_f);
    chk("done_at_grant", {frame_done, timeout_err}, 0);
    req = wait_req;
    frame_data = {rand256(), rand256()};
    done_exp = (lat <= TIMEOUT - 1);
    last = done_exp ? lat + 1 : TIMEOUT;
    for (int j = 1; j <= last; j++) begin
      tick();
      chk("no_grant_in_wait", {grant, ser_start}, 0);
      chk("frame_done", frame_done, (done_exp && j == last) ? oh(exp_k) : 2'b00);
      chk("timeout_err", timeout_err, (!done_exp && j == last));
      chk("busy", busy, (j < last));
      chk("ser_data_hold", ser_data, exp_f);
      if (j == last) chk("owner_hold", owner, exp_k);
      ser_done = (j == lat);
    end
    ser_done = 1'b0;
    ptr_m = (exp_k + 1) % 2;
  endtask

  // Idle cycles with no requests; ser_done must be ignored.
  task automatic idle_cycles(input int n, input bit force_done);
    req = 2'b00;
    for (int i = 0; i < n; i++) begin
      ser_done = force_done ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      chk("idle_grant", {grant, ser_start}, 0);
      chk("idle_done", {frame_done, timeout_err}, 0);
      chk("idle_busy", busy, 0);
    end
    ser_done = 1'b0;
    tick();
    chk("idle_tail", {grant, ser_start, frame_done, timeout_err, busy}, 0);
  endtask

  initial begin
    logic [1:0] r;
    int lat, sel, k;
    logic [FW-1:0] f0, f1;

    n_chk = 0;
    n_fail = 0;
    ptr_m = 0;

    vecs[0] = '{req: 2'b01, lat: 17,  exp_k: 0};
    vecs[1] = '{req: 2'b11, lat: 17,  exp_k: 1};
    vecs[2] = '{req: 2'b11, lat: 17,  exp_k: 0};
    vecs[3] = '{req: 2'b11, lat: 63,  exp_k: 1};
    vecs[4] = '{req: 2'b10, lat: 999, exp_k: 1};
    vecs[5] = '{req: 2'b10, lat: 17,  exp_k: 1};
    vecs[6] = '{req: 2'b11, lat: 64,  exp_k: 0};
    vecs[7] = '{req: 2'b01, lat: 1,   exp_k: 0};
    vecs[8] = '{req: 2'b11, lat: 2,   exp_k: 1};

    reset_n = 1'b0;
    req = 2'b00;
    frame_data = '0;
    ser_done = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;

    idle_cycles(4, 1'b1);

    for (int i = 0; i < 9; i++) begin
      run_xfer(vecs[i].req, vecs[i].lat, vecs[i].exp_k, vecs[i].req);
    end

    idle_cycles(3, 1'b0);

    for (int t = 0; t < 40; t++) begin
      r = 2'($urandom_range(1, 3));
      sel = $urandom_range(0, 9);
      if (sel < 7)       lat = $urandom_range(1, 40);
      else if (sel == 7) lat = 63;
      else if (sel == 8) lat = 62;
      else               lat = $urandom_range(64, 80);
      k = rr_pick(ptr_m, r);
      run_xfer(r, lat, k, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'b0);
    end

    // Reset in the middle of a transfer; pointer must return to 0.
    run_xfer(2'b01, 17, 0, 2'b00);
    f0 = rand256();
    f1 = rand256();
    frame_data = {f1, f0};
    req = 2'b11;
    tick();
    chk("pre_reset_grant", grant, 2'b10);
    req = 2'b00;
    repeat (8) tick();
    chk("pre_reset_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    check_all_zero("held_reset");
    reset_n = 1'b1;
    req = 2'b11;
    tick();
    chk("post_reset_grant", grant, 2'b01);
    chk("post_reset_owner", owner, 0);
    chk("post_reset_data", ser_data, f0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
